// File: rtl/mult_job_sequencer.sv
// Operand FIFO plus single-job sequencer for the repetitive-addition multiplier.
// Products (or timeout markers) are returned on a valid/ready result port.
module mult_job_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 300
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_r,
    output logic                       out_err,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_r,
    input  logic                       mul_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     fifo_a_q [DEPTH];
    logic [WIDTH-1:0]     fifo_b_q [DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   out_r_q, out_r_d;
    logic                 out_err_q, out_err_d;
    logic                 out_valid_q, out_valid_d;
    logic                 mul_start_q, mul_start_d;
    logic                 busy_q, busy_d;
    logic                 push, pop, load_head;

    assign push = in_valid && in_ready_q;
    assign pop  = (state_q == S_ISSUE);

    // Occupancy and pointers; in_ready is re-derived from the next count only.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d < CW'(DEPTH));
    end

    // Operands are loaded on the way into ISSUE so mul_a/mul_b are valid with mul_start.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        out_r_d   = out_r_q;
        out_err_d = out_err_q;
        load_head = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d   = S_ISSUE;
                    load_head = 1'b1;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mul_ready) begin
                    out_r_d   = mul_r;
                    out_err_d = 1'b0;
                    state_d   = S_HOLD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    out_r_d   = '0;
                    out_err_d = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (count_q != '0) begin
                        state_d   = S_ISSUE;
                        load_head = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load_head) begin
            mul_a_d = fifo_a_q[rptr_q];
            mul_b_d = fifo_b_q[rptr_q];
        end
        out_valid_d = (state_d == S_HOLD);
        mul_start_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            timer_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_r_q     <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            timer_q     <= timer_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_r_q     <= out_r_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            mul_start_q <= mul_start_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a_q[wptr_q] <= in_a;
            fifo_b_q[wptr_q] <= in_b;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_err   = out_err_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Randomized bench for mult_job_sequencer: behavioural multiplier stub, result
// scoreboard, occupancy model and start-to-result latency expectations.
module tb_mult_job_sequencer;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    typedef struct {
        logic [2*WIDTH-1:0] r;
        logic               err;
    } res_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a = '0;
    logic [WIDTH-1:0]     in_b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [2*WIDTH-1:0]   out_r;
    logic                 out_err;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_r = '0;
    logic                 mul_ready = 1'b1;
    logic                 busy;
    logic [CW-1:0]        count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    res_t        exp_q[$];
    bit          hang_q[$];
    int          m_cnt = 0;
    bit          mon_en = 0;
    bit          rnd_ready = 0;
    bit          hold_high = 0;
    bit          inflight = 0;
    bit          st_hang = 0;
    int unsigned st_cnt = 0;
    int unsigned st_lat = 0;
    int unsigned st_cyc = 0;
    int unsigned cyc = 0;
    logic [WIDTH-1:0] sa = '0;
    logic [WIDTH-1:0] sb = '0;
    logic        prev_ov = 1'b0;
    logic        prev_start = 1'b0;

    mult_job_sequencer #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_err  (out_err),
        .mul_start(mul_start),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_r    (mul_r),
        .mul_ready(mul_ready),
        .busy     (busy),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier stub: the i-th start consumes the i-th hang tag; a hung job never
    // raises mul_ready, a normal one raises it with the product after a random latency.
    always @(posedge clock) begin : stub
        bit          h;
        int unsigned l;
        cyc <= cyc + 1;
        if (reset) begin
            mul_ready <= 1'b1;
            st_cnt    <= 0;
            inflight  <= 1'b0;
        end else if (mul_start) begin
            h = (hang_q.size() > 0) ? hang_q.pop_front() : 1'b0;
            l = hold_high ? 1 : $urandom_range(1, 12);
            sa        <= mul_a;
            sb        <= mul_b;
            st_hang   <= h;
            st_lat    <= l;
            st_cyc    <= cyc;
            inflight  <= 1'b1;
            st_cnt    <= h ? 0 : l;
            mul_ready <= hold_high;
        end else begin
            if (out_valid) inflight <= 1'b0;
            if (st_cnt == 1) begin
                mul_r     <= {{WIDTH{1'b0}}, sa} * {{WIDTH{1'b0}}, sb};
                mul_ready <= 1'b1;
            end
            if (st_cnt != 0) st_cnt <= st_cnt - 1;
        end
    end

    always @(posedge clock) begin
        if (reset) m_cnt <= 0;
        else m_cnt <= m_cnt + ((in_valid && m_cnt < int'(DEPTH)) ? 1 : 0) - (mul_start ? 1 : 0);
    end

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            check("count", 32'(count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(m_cnt < int'(DEPTH)));
            if (mul_start) begin
                check("start_nonempty", 32'(m_cnt > 0), 1);
                check("start_pulse", 32'(prev_start), 0);
            end
            if (inflight && !out_valid && !mul_start) begin
                check("mul_a_hold", 32'(mul_a), 32'(sa));
                check("mul_b_hold", 32'(mul_b), 32'(sb));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 0);
                end else begin
                    check("out_r", 32'(out_r), 32'(exp_q[0].r));
                    check("out_err", 32'(out_err), 32'(exp_q[0].err));
                    if (!prev_ov)
                        check("latency", cyc - st_cyc, st_hang ? TIMEOUT + 2 : st_lat + 2);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_ov    <= out_valid;
        prev_start <= mul_start;
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hang);
        int unsigned w = 0;
        res_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && w < 2000) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (!in_ready) begin
            check("push_accept", 32'(in_ready), 1);
        end else begin
            e.r   = hang ? '0 : ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
            e.err = hang;
            exp_q.push_back(e);
            hang_q.push_back(hang);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || m_cnt != 0) && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
        check("busy_idle", 32'(busy), 0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_r", 32'(out_r), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        mon_en = 1;

        // start latency from a push into an empty idle block
        out_ready = 1'b1;
        push_job(8'd3, 8'd4, 0);
        check("lat_e0_start", 32'(mul_start), 0);
        @(posedge clock);
        #1;
        check("lat_e1_start", 32'(mul_start), 1);
        @(posedge clock);
        #1;
        check("start_one_cycle", 32'(mul_start), 0);
        wait_drain();

        push_job(8'h34, 8'h04, 0);
        push_job(8'hFF, 8'hFF, 0);
        push_job(8'h00, 8'h7F, 0);
        wait_drain();

        // back-to-back pushes into a stalled consumer
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) push_job(8'(i + 10), 8'(i + 3), 0);
        for (int unsigned n = 0; n < 100 && !out_valid; n++) begin
            @(posedge clock);
            #1;
        end
        check("stall_valid", 32'(out_valid), 1);
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        repeat (10) @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // timeout then a normal job behind it
        push_job(8'h11, 8'h22, 1);
        push_job(8'h05, 8'h06, 0);
        wait_drain();

        // reset while waiting, two jobs still queued
        push_job(8'h21, 8'h03, 1);
        push_job(8'h01, 8'h02, 0);
        push_job(8'h03, 8'h04, 0);
        repeat (10) @(posedge clock);
        #1;
        check("pre_rst_count", 32'(count), 2);
        reset = 1'b1;
        exp_q.delete();
        hang_q.delete();
        @(posedge clock);
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_mul_start", 32'(mul_start), 0);
        check("mid_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("post_rst_busy", 32'(busy), 0);

        // multiplier that keeps mul_ready high throughout
        hold_high = 1;
        push_job(8'h12, 8'h34, 0);
        wait_drain();
        push_job(8'h0A, 8'h0B, 0);
        wait_drain();
        hold_high = 0;

        // random traffic with random consumer back-pressure
        rnd_ready = 1;
        for (int unsigned j = 0; j < 60; j++) begin
            push_job(rnd_op(), rnd_op(), 0);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        rnd_ready = 0;
        #1;
        out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
